vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Programmable VGA raster timing generator for the 25 MHz pixel domain. It produces the sync pulses, the data-enable and the active-pixel coordinates that the colour pattern stage consumes. It replaces free-running x/y counters with a per-axis porch/sync state machine and aligned registered outputs. Defaults give 640x480 at 60 Hz: 800 clocks per line, 525 lines per frame.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of o_hsync (0 = active-low)
- VS_POL, 0, asserted level of o_vsync
- clk25MHz  in  1  pixel clock; the block has one clock domain
- reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  advance raster when 1; freeze when 0
- o_hsync  out  1  horizontal sync, polarity per HS_POL
- o_vsync  out  1  vertical sync, polarity per VS_POL
- o_de  out  1  1 while the output pixel is in the visible area
- o_x  out  10  active column 0..H_ACTIVE-1; 0 when o_de=0
- o_y  out  10  active line 0..V_ACTIVE-1; 0 when the line is blanked
- o_line_start  out  1  one-cycle pulse at h=0 of every line, blanked lines included
- o_frame_start  out  1  one-cycle pulse at h=0, v=0

## Operation
- Internal counters h_cnt and v_cnt are 10 bits each. Every parameter is at least 1. Each axis total must be no more than 1024; that is a parameter-legality rule only, with no runtime check.
- Horizontal FSM order: H_ACT (h 0..639), then H_FP (640..655), then H_SYNC (656..751), then H_BP (752..799), then back to H_ACT.
- A state transitions when its segment counter reaches length-1. The segment counter clears on every transition.
- Vertical FSM order: V_ACT (lines 0..479), then V_FP (480..489), then V_SYNC (490..491), then V_BP (492..524), then back to V_ACT.
- The vertical FSM advances only on a cycle where i_enable=1 and h_cnt=799, which is the end of line.
- At h_cnt=799 and v_cnt=524 both counters wrap to 0 on the same edge.
- Decode: de = (H_ACT && V_ACT). hsync is asserted in H_SYNC and vsync in V_SYNC. Otherwise each sync sits at its inverted level.
- i_enable=0: counters and FSMs hold, o_de is forced to 0, both start pulses are forced to 0, and the syncs hold their last value. Raising i_enable resumes from the held position with no skipped pixel.
- Reset (asynchronous assert, any time including mid-frame):
  - counters go to 0 and the FSMs to H_ACT/V_ACT;
  - o_hsync = ~HS_POL, o_vsync = ~VS_POL;
  - o_de, o_x, o_y, o_line_start and o_frame_start are all 0.
- Reset release is synchronous to clk25MHz. The raster always restarts at (0,0).

## Timing
- All outputs are registered. An output on edge k+1 reflects the counter state at edge k, so every output shares the same 1-clock latency and all outputs stay mutually aligned.
- First enabled edge after reset release: o_de=1, o_x=0, o_y=0, o_line_start=1, o_frame_start=1.
- o_line_start period is 800 enabled clocks. o_frame_start period is 420000 enabled clocks.
- o_hsync low width is 96 clocks. o_vsync low width is 1600 clocks (2 lines). The vsync edges coincide with a line_start edge.
- The downstream colour stage registers colour once. It must delay o_hsync/o_vsync by one clock to stay aligned with its colour output.

## Test plan
- Reset values: hold reset_n=0 for 5 cycles with i_enable=1. Required: o_hsync=1, o_vsync=1, o_de=0, o_x=0, o_y=0, both pulses 0.
- First line: release reset, keep i_enable=1.
  - o_de=1 for exactly 640 clocks, with o_x counting 0..639.
  - Then o_de=0.
  - o_hsync=0 on line clocks 656..751, i.e. 96 clocks.
  - Next o_line_start arrives 800 clocks after the first.
- Full frame:
  - o_y=479 on the last active line; o_de stays 0 on lines 480..524.
  - o_vsync=0 for exactly lines 490..491.
  - o_frame_start pulses are 420000 clocks apart and each coincides with o_line_start.
- Stall: drop i_enable for 37 cycles at o_x=300.
  - During the stall o_de=0, pulses stay 0 and o_hsync is steady.
  - After re-enable, o_x continues at 301 and the line ends 37 clocks later than unstalled.
- Reset mid-frame: assert reset_n=0 asynchronously at y=250, x=500.
  - Outputs go to reset values without waiting for a clock edge.
  - After release, the first output is x=0, y=0 with o_frame_start=1.
- Non-default parameters (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, HS_POL=1): 16-clock lines, 8-line frames, o_hsync=1 on clocks 10..12 of each line.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator and the colour pattern stage.
// The generator is the master: it receives the advance enable and drives the
// syncs, data-enable, coordinates and start pulses.
interface vga_timing_gen_if;
  logic       i_enable;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_de;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       o_line_start;
  logic       o_frame_start;

  modport master (
    input  i_enable,
    output o_hsync, o_vsync, o_de, o_x, o_y, o_line_start, o_frame_start
  );

  modport slave (
    output i_enable,
    input  o_hsync, o_vsync, o_de, o_x, o_y, o_line_start, o_frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator (single 25 MHz pixel domain).
// Each axis walks ACT -> FP -> SYNC -> BP with its own segment counter.
// All outputs are registered from the counter state of the previous edge,
// so they share one clock of latency and stay mutually aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                  clk25MHz,
  input  logic                  reset_n,
  vga_timing_gen_if.master      vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_FP - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC - 1);
  localparam logic [9:0] H_BP_END   = 10'(H_BP - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_FP - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC - 1);
  localparam logic [9:0] V_BP_END   = 10'(V_BP - 1);

  // Both axes share the same segment order, so one encoding serves both.
  typedef enum logic [1:0] {
    SEG_ACT,
    SEG_FP,
    SEG_SYNC,
    SEG_BP
  } seg_t;

  function automatic seg_t seg_next(input seg_t s);
    case (s)
      SEG_ACT:  return SEG_FP;
      SEG_FP:   return SEG_SYNC;
      SEG_SYNC: return SEG_BP;
      default:  return SEG_ACT;
    endcase
  endfunction

  seg_t       h_state, h_state_nxt;
  seg_t       v_state, v_state_nxt;
  logic [9:0] h_seg, h_seg_nxt, h_seg_last;
  logic [9:0] v_seg, v_seg_nxt, v_seg_last;
  logic [9:0] h_cnt, h_cnt_nxt;
  logic [9:0] v_cnt, v_cnt_nxt;
  logic       line_end;

  // The vertical axis steps once per completed, enabled line.
  assign line_end = vga.i_enable && (h_cnt == H_LAST);

  // Horizontal next-state: pixel counter plus porch/sync segment walk.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    h_state_nxt = h_state;
    h_seg_nxt   = h_seg;
    h_cnt_nxt   = h_cnt;
    h_seg_last  = H_ACT_END;
    case (h_state)
      SEG_ACT:  h_seg_last = H_ACT_END;
      SEG_FP:   h_seg_last = H_FP_END;
      SEG_SYNC: h_seg_last = H_SYNC_END;
      default:  h_seg_last = H_BP_END;
    endcase
    if (vga.i_enable) begin
      h_cnt_nxt = (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
      if (h_seg == h_seg_last) begin
        h_seg_nxt   = '0;
        h_state_nxt = seg_next(h_state);
      end else begin
        h_seg_nxt = h_seg + 10'd1;
      end
    end
  end

  // Vertical next-state: same walk, advanced only at the end of a line.
  always_comb begin
    v_state_nxt = v_state;
    v_seg_nxt   = v_seg;
    v_cnt_nxt   = v_cnt;
    v_seg_last  = V_ACT_END;
    case (v_state)
      SEG_ACT:  v_seg_last = V_ACT_END;
      SEG_FP:   v_seg_last = V_FP_END;
      SEG_SYNC: v_seg_last = V_SYNC_END;
      default:  v_seg_last = V_BP_END;
    endcase
    if (line_end) begin
      v_cnt_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      if (v_seg == v_seg_last) begin
        v_seg_nxt   = '0;
        v_state_nxt = seg_next(v_state);
      end else begin
        v_seg_nxt = v_seg + 10'd1;
      end
    end
  end

  // State and counter registers; reset restarts the raster at (0,0).
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      h_state <= SEG_ACT;
      v_state <= SEG_ACT;
      h_seg   <= '0;
      v_seg   <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
      h_seg   <= h_seg_nxt;
      v_seg   <= v_seg_nxt;
      h_cnt   <= h_cnt_nxt;
      v_cnt   <= v_cnt_nxt;
    end
  end

  // Output decode registered from the current (pre-advance) position.
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      vga.o_hsync       <= ~HS_POL;
      vga.o_vsync       <= ~VS_POL;
      vga.o_de          <= 1'b0;
      vga.o_x           <= '0;
      vga.o_y           <= '0;
      vga.o_line_start  <= 1'b0;
      vga.o_frame_start <= 1'b0;
    end else if (vga.i_enable) begin
      vga.o_hsync       <= (h_state == SEG_SYNC) ? HS_POL : ~HS_POL;
      vga.o_vsync       <= (v_state == SEG_SYNC) ? VS_POL : ~VS_POL;
      vga.o_de          <= (h_state == SEG_ACT) && (v_state == SEG_ACT);
      vga.o_x           <= ((h_state == SEG_ACT) && (v_state == SEG_ACT)) ? h_cnt : '0;
      vga.o_y           <= (v_state == SEG_ACT) ? v_cnt : '0;
      vga.o_line_start  <= (h_cnt == '0);
      vga.o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      // Frozen raster: blank the pixel and suppress pulses; syncs and the
      // line number keep their last value.
      vga.o_de          <= 1'b0;
      vga.o_x           <= '0;
      vga.o_line_start  <= 1'b0;
      vga.o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and a
// small-parameter instance, both compared cycle by cycle against a model
// that tracks the raster position as plain integers.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_n [2];
  logic en    [2];

  vga_timing_gen_if if_d ();
  vga_timing_gen_if if_s ();

  assign if_d.i_enable = en[0];
  assign if_s.i_enable = en[1];

  vga_timing_gen dut_d (
    .clk25MHz (clk),
    .reset_n  (rst_n[0]),
    .vga      (if_d)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (2),
    .HS_POL   (1'b1), .VS_POL (1'b0)
  ) dut_s (
    .clk25MHz (clk),
    .reset_n  (rst_n[1]),
    .vga      (if_s)
  );

  // Timing parameters per instance: index 0 = default, 1 = small.
  int HA  [2] = '{640, 8};
  int HFP [2] = '{16, 2};
  int HSW [2] = '{96, 3};
  int HBP [2] = '{48, 3};
  int VA  [2] = '{480, 4};
  int VFP [2] = '{10, 1};
  int VSW [2] = '{2, 1};
  int VBP [2] = '{33, 2};
  bit HP  [2] = '{1'b0, 1'b1};
  bit VP  [2] = '{1'b0, 1'b0};

  // Model: raster position and the outputs expected after the next edge.
  int   mh [2];
  int   mv [2];
  logic e_hs [2];
  logic e_vs [2];
  logic e_de [2];
  logic e_ls [2];
  logic e_fs [2];
  int   e_x  [2];
  int   e_y  [2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    mh[i]   = 0;
    mv[i]   = 0;
    e_hs[i] = ~HP[i];
    e_vs[i] = ~VP[i];
    e_de[i] = 1'b0;
    e_ls[i] = 1'b0;
    e_fs[i] = 1'b0;
    e_x[i]  = 0;
    e_y[i]  = 0;
  endtask

  // One clock edge of the reference raster.
  task automatic model_step(input int i, input bit e);
    int ht;
    int vt;
    int hs0;
    int vs0;
    ht  = HA[i] + HFP[i] + HSW[i] + HBP[i];
    vt  = VA[i] + VFP[i] + VSW[i] + VBP[i];
    hs0 = HA[i] + HFP[i];
    vs0 = VA[i] + VFP[i];
    if (e) begin
      e_de[i] = (mh[i] < HA[i]) && (mv[i] < VA[i]);
      e_x[i]  = e_de[i] ? mh[i] : 0;
      e_y[i]  = (mv[i] < VA[i]) ? mv[i] : 0;
      e_hs[i] = (mh[i] >= hs0 && mh[i] < hs0 + HSW[i]) ? HP[i] : ~HP[i];
      e_vs[i] = (mv[i] >= vs0 && mv[i] < vs0 + VSW[i]) ? VP[i] : ~VP[i];
      e_ls[i] = (mh[i] == 0);
      e_fs[i] = (mh[i] == 0) && (mv[i] == 0);
      mh[i]++;
      if (mh[i] == ht) begin
        mh[i] = 0;
        mv[i]++;
        if (mv[i] == vt) mv[i] = 0;
      end
    end else begin
      e_de[i] = 1'b0;
      e_x[i]  = 0;
      e_ls[i] = 1'b0;
      e_fs[i] = 1'b0;
    end
  endtask

  task automatic check_all(input int i);
    logic hs, vs, de, ls, fs;
    int   x, y;
    if (i == 0) begin
      hs = if_d.o_hsync; vs = if_d.o_vsync; de = if_d.o_de;
      ls = if_d.o_line_start; fs = if_d.o_frame_start;
      x  = int'(if_d.o_x); y = int'(if_d.o_y);
    end else begin
      hs = if_s.o_hsync; vs = if_s.o_vsync; de = if_s.o_de;
      ls = if_s.o_line_start; fs = if_s.o_frame_start;
      x  = int'(if_s.o_x); y = int'(if_s.o_y);
    end
    check($sformatf("u%0d.hsync", i), hs, e_hs[i]);
    check($sformatf("u%0d.vsync", i), vs, e_vs[i]);
    check($sformatf("u%0d.de", i), de, e_de[i]);
    check($sformatf("u%0d.x", i), x, e_x[i]);
    check($sformatf("u%0d.y", i), y, e_y[i]);
    check($sformatf("u%0d.line_start", i), ls, e_ls[i]);
    check($sformatf("u%0d.frame_start", i), fs, e_fs[i]);
  endtask

  task automatic cycle(input int i, input bit e);
    @(negedge clk);
    en[i] = e;
    model_step(i, e);
    @(posedge clk);
    #1;
    check_all(i);
  endtask

  // Hold reset with enable high for five edges, then release on a falling
  // edge and check the first enabled edge.
  task automatic reset_and_release(input int i);
    rst_n[i] = 1'b0;
    en[i]    = 1'b1;
    model_reset(i);
    repeat (5) begin
      @(posedge clk);
      #1;
      check_all(i);
    end
    @(negedge clk);
    rst_n[i] = 1'b1;
    model_step(i, 1'b1);
    @(posedge clk);
    #1;
    check_all(i);
  endtask

  initial begin
    int n;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    en[0]    = 1'b0;
    en[1]    = 1'b0;
    model_reset(0);
    model_reset(1);

    // Default timing: first line, stall at x=300, more lines, random enable.
    reset_and_release(0);
    n = 0;
    while (!(e_de[0] && e_x[0] == 300) && n < 1000) begin
      cycle(0, 1'b1);
      n++;
    end
    check("u0.reach_x300", (n < 1000), 1'b1);
    repeat (37) cycle(0, 1'b0);
    repeat (1700) cycle(0, 1'b1);
    repeat (900) cycle(0, $urandom_range(0, 3) != 0);
    rst_n[0] = 1'b0;
    en[0]    = 1'b0;

    // Small timing: several frames with random stalls, then clean frames.
    reset_and_release(1);
    repeat (400) cycle(1, $urandom_range(0, 4) != 0);
    repeat (300) cycle(1, 1'b1);

    // Asynchronous reset mid-frame, then restart from (0,0).
    n = 0;
    while (!(e_de[1] && e_x[1] == 5 && e_y[1] == 2) && n < 1000) begin
      cycle(1, 1'b1);
      n++;
    end
    check("u1.reach_mid", (n < 1000), 1'b1);
    #10;
    rst_n[1] = 1'b0;
    model_reset(1);
    #1;
    check_all(1);
    reset_and_release(1);
    repeat (200) cycle(1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
